jtpopeye_objscan: RTL and testbench

- Downstream consumer of the object DMA.
- Once per scan line it walks the object RAM that the DMA filled through DMCS0..3. It selects the objects that intersect the next displayed line.
- Each selected object is streamed to the object line-buffer renderer over a valid/ready handshake.
- Runs on the system clock; line timing comes from the video timing generator (V, HB) qualified by pxl_cen.

---
 rtl/jtpopeye_obj_pkg.sv | 13 +
 rtl/jtpopeye_objscan_cmp.sv | 15 +
 rtl/jtpopeye_objscan.sv | 130 +++++++++++++
 tb/tb_jtpopeye_objscan.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/jtpopeye_obj_pkg.sv
// jtpopeye_obj_pkg: shared scanner states, object byte lanes and object height.
package jtpopeye_obj_pkg;
    typedef enum logic [2:0] {IDLE, RD, CHK, EMIT, DONE} state_e;
    // Byte lanes follow the DMCS0..3 bank order
    localparam int LANE_Y    = 0;
    localparam int LANE_X    = 1;
    localparam int LANE_CODE = 2;
    localparam int LANE_ATTR = 3;
    localparam int OBJH      = 16;
    function automatic logic [7:0] obj_byte(input logic [31:0] d, input int lane);
        return d[lane*8 +: 8];
    endfunction
endpackage

// File: rtl/jtpopeye_objscan_cmp.sv
// jtpopeye_objscan_cmp: checks whether an object spans the target line and gives its row.
module jtpopeye_objscan_cmp #(
    parameter int OBJH = 16
) (
    input  logic [7:0] tgt_i,
    input  logic [7:0] y_i,
    output logic       hit_o,
    output logic [3:0] row_o
);
    logic [7:0] d;
    assign d     = tgt_i - y_i;
    // y == 0 marks an empty slot
    assign hit_o = (y_i != 8'd0) && (d < 8'(OBJH));
    assign row_o = d[3:0];
endmodule

// File: rtl/jtpopeye_objscan.sv
// jtpopeye_objscan: per-line object RAM scan streaming line hits to the renderer.
// Define JTPOPEYE_OBJ_VFLIP_EN to honour attr[7] as a vertical flip bit.
module jtpopeye_objscan #(
    parameter int NOBJ   = 96,
    parameter int AW     = 7,
    parameter int MAXHIT = 24,
    parameter int OBJH   = jtpopeye_obj_pkg::OBJH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic [7:0]    V,
    input  logic          HB,
    output logic [AW-1:0] obj_addr,
    input  logic [31:0]   obj_data,
    output logic          hit_valid,
    input  logic          hit_ready,
    output logic [7:0]    hit_x,
    output logic [7:0]    hit_code,
    output logic [7:0]    hit_attr,
    output logic [3:0]    hit_row,
    output logic          hit_last,
    output logic          scan_busy,
    output logic          ovf
);
    import jtpopeye_obj_pkg::*;
    localparam int CW = $clog2(MAXHIT + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NOBJ - 1);
    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    tgt_q, tgt_d, x_q, x_d, code_q, code_d, attr_q, attr_d;
    logic [3:0]    row_q, row_d, row_c, row_l;
    logic [7:0]    attr_l;
    logic          ovf_q, ovf_d, hb_q, start, hit, last;
    assign start = pxl_cen && HB && !hb_q;
    jtpopeye_objscan_cmp #(.OBJH(OBJH)) u_cmp (
        .tgt_i (tgt_q),
        .y_i   (obj_byte(obj_data, LANE_Y)),
        .hit_o (hit),
        .row_o (row_c)
    );
`ifdef JTPOPEYE_OBJ_VFLIP_EN
    assign row_l  = obj_data[LANE_ATTR*8+7] ? ~row_c : row_c;
    assign attr_l = {1'b0, obj_data[LANE_ATTR*8 +: 7]};
`else
    assign row_l  = row_c;
    assign attr_l = obj_byte(obj_data, LANE_ATTR);
`endif
    // The transfer that finishes the scan is flagged as the line's last entry
    assign last = (idx_q == LAST_IDX) || (cnt_q == CW'(MAXHIT - 1));
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        ovf_d   = ovf_q;
        x_d     = x_q;
        code_d  = code_q;
        attr_d  = attr_q;
        row_d   = row_q;
        if (start) begin
            state_d = RD;
            tgt_d   = V + 8'd1;
            idx_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                RD:   state_d = CHK;
                CHK: begin
                    if (hit) begin
                        state_d = EMIT;
                        x_d     = obj_byte(obj_data, LANE_X);
                        code_d  = obj_byte(obj_data, LANE_CODE);
                        attr_d  = attr_l;
                        row_d   = row_l;
                    end else begin
                        state_d = (idx_q == LAST_IDX) ? DONE : RD;
                        idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + 1'b1;
                    end
                end
                EMIT: begin
                    if (hit_ready) begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = last ? DONE : RD;
                        idx_d   = last ? idx_q : idx_q + 1'b1;
                        ovf_d   = (cnt_q == CW'(MAXHIT - 1)) && (idx_q != LAST_IDX);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tgt_q   <= '0;
            ovf_q   <= 1'b0;
            x_q     <= '0;
            code_q  <= '0;
            attr_q  <= '0;
            row_q   <= '0;
            hb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            ovf_q   <= ovf_d;
            x_q     <= x_d;
            code_q  <= code_d;
            attr_q  <= attr_d;
            row_q   <= row_d;
            hb_q    <= pxl_cen ? HB : hb_q;
        end
    end
    assign obj_addr  = idx_q;
    assign hit_valid = (state_q == EMIT);
    assign hit_last  = hit_valid && last;
    assign scan_busy = (state_q == RD) || (state_q == CHK) || (state_q == EMIT);
    assign ovf       = ovf_q;
    assign hit_x     = x_q;
    assign hit_code  = code_q;
    assign hit_attr  = attr_q;
    assign hit_row   = row_q;
endmodule

// File: tb/tb_jtpopeye_objscan.sv
// tb_jtpopeye_objscan: directed vector bench for the per-line object scanner.
module tb_jtpopeye_objscan;
    logic        clk = 1'b0, rst = 1'b1, pxl_cen = 1'b1, HB = 1'b0, hit_ready = 1'b1;
    logic [7:0]  V = 8'd0;
    logic [6:0]  obj_addr;
    logic [31:0] obj_data;
    logic        hit_valid, hit_last, scan_busy, ovf;
    logic [7:0]  hit_x, hit_code, hit_attr;
    logic [3:0]  hit_row;
    logic [31:0] ram [128];
    int          tests = 0, errors = 0, busy_cyc;

    typedef struct {
        logic [7:0] x, code, attr;
        logic [3:0] row;
        logic       last;
    } ent_t;
    ent_t got[$];

    typedef struct {
        int         idx;
        logic [7:0] y, x, code, attr, v;
        logic       hit;
        logic [3:0] row;
        int         busy;
    } vec_t;
    vec_t vt[8];

    jtpopeye_objscan dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .V(V), .HB(HB),
        .obj_addr(obj_addr), .obj_data(obj_data),
        .hit_valid(hit_valid), .hit_ready(hit_ready),
        .hit_x(hit_x), .hit_code(hit_code), .hit_attr(hit_attr), .hit_row(hit_row),
        .hit_last(hit_last), .scan_busy(scan_busy), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) obj_data <= ram[obj_addr];

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 128; i++) ram[i] = 32'd0;
    endtask

    task automatic start_line(input logic [7:0] v);
        @(negedge clk);
        V  = v;
        HB = 1'b1;
        @(negedge clk);
        HB = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready high one cycle in four
    task automatic collect(input int mode);
        ent_t hold;
        logic stalled = 1'b0;
        int   c;
        got.delete();
        busy_cyc = 0;
        for (c = 0; c < 2000; c++) begin
            if (!scan_busy) break;
            busy_cyc++;
            hit_ready = (mode == 0) ? 1'b1 : (c % 4 == 3);
            if (stalled && hit_valid) begin
                chk("stall_x", hit_x, hold.x);
                chk("stall_row", hit_row, hold.row);
                chk("stall_code", hit_code, hold.code);
            end
            if (hit_valid) begin
                hold = '{hit_x, hit_code, hit_attr, hit_row, hit_last};
                if (hit_ready) got.push_back(hold);
            end
            stalled = hit_valid && !hit_ready;
            @(negedge clk);
        end
        if (c == 2000) chk("scan_timeout", 1, 0);
        hit_ready = 1'b1;
    endtask

    initial begin
        logic [7:0] ea;
        logic [3:0] er;
        vt[0] = '{5,   8'd40,  8'd100, 8'd7, 8'h00, 8'd44,  1'b1, 4'd5,  193};
        vt[1] = '{0,   8'd250, 8'd11,  8'd1, 8'h00, 8'd255, 1'b1, 4'd6,  193};
        vt[2] = '{95,  8'd44,  8'd200, 8'd3, 8'h05, 8'd44,  1'b1, 4'd1,  193};
        vt[3] = '{10,  8'd40,  8'd1,   8'd1, 8'h00, 8'd55,  1'b0, 4'd0,  192};
        vt[4] = '{10,  8'd40,  8'd1,   8'd1, 8'h00, 8'd38,  1'b0, 4'd0,  192};
        vt[5] = '{3,   8'd0,   8'd1,   8'd1, 8'h00, 8'd255, 1'b0, 4'd0,  192};
        vt[6] = '{7,   8'd30,  8'd50,  8'd9, 8'h80, 8'd44,  1'b1, 4'd15, 193};
        vt[7] = '{5,   8'd40,  8'd100, 8'd7, 8'h80, 8'd44,  1'b1, 4'd5,  193};
        clear_ram();
        repeat (3) @(negedge clk);
        chk("rst_busy", scan_busy, 0);
        chk("rst_valid", hit_valid, 0);
        chk("rst_addr", obj_addr, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_x", hit_x, 0);
        chk("rst_last", hit_last, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            clear_ram();
            ram[vt[i].idx] = {vt[i].attr, vt[i].code, vt[i].x, vt[i].y};
            start_line(vt[i].v);
            collect(0);
            chk($sformatf("v%0d_nhits", i), got.size(), int'(vt[i].hit));
            chk($sformatf("v%0d_busy", i), busy_cyc, vt[i].busy);
            chk($sformatf("v%0d_ovf", i), ovf, 0);
            if (vt[i].hit && got.size() == 1) begin
`ifdef JTPOPEYE_OBJ_VFLIP_EN
                ea = vt[i].attr & 8'h7f;
                er = vt[i].attr[7] ? ~vt[i].row : vt[i].row;
`else
                ea = vt[i].attr;
                er = vt[i].row;
`endif
                chk($sformatf("v%0d_x", i), got[0].x, vt[i].x);
                chk($sformatf("v%0d_code", i), got[0].code, vt[i].code);
                chk($sformatf("v%0d_attr", i), got[0].attr, ea);
                chk($sformatf("v%0d_row", i), got[0].row, er);
                chk($sformatf("v%0d_last", i), got[0].last, int'(vt[i].idx == 95));
            end
        end

        // Overflow: every slot hits, scan stops at MAXHIT
        for (int i = 0; i < 96; i++) ram[i] = {8'h00, 8'd2, 8'(i), 8'd10};
        start_line(8'd12);
        collect(0);
        chk("ovf_n", got.size(), 24);
        chk("ovf_flag", ovf, 1);
        chk("ovf_busy", busy_cyc, 72);
        if (got.size() == 24) begin
            chk("ovf_last24", got[23].last, 1);
            chk("ovf_last23", got[22].last, 0);
            chk("ovf_row", got[23].row, 3);
            chk("ovf_x24", got[23].x, 23);
        end

        // Backpressure: three hits, ready one cycle in four
        clear_ram();
        ram[2]  = {8'h00, 8'd4, 8'd1, 8'd40};
        ram[50] = {8'h00, 8'd5, 8'd2, 8'd35};
        ram[95] = {8'h00, 8'd6, 8'd3, 8'd44};
        start_line(8'd44);
        collect(1);
        chk("bp_n", got.size(), 3);
        chk("bp_ovf_clr", ovf, 0);
        if (got.size() == 3) begin
            chk("bp_x0", got[0].x, 1);
            chk("bp_row1", got[1].row, 10);
            chk("bp_x2", got[2].x, 3);
            chk("bp_last1", got[1].last, 0);
            chk("bp_last2", got[2].last, 1);
        end

        // Abort: new line start while stalled in EMIT
        clear_ram();
        ram[10] = {8'h00, 8'd0, 8'd5, 8'd40};
        ram[40] = {8'h00, 8'd0, 8'd9, 8'd90};
        hit_ready = 1'b0;
        start_line(8'd44);
        repeat (58) @(negedge clk);
        chk("ab_stall_valid", hit_valid, 1);
        chk("ab_stall_addr", obj_addr, 10);
        V  = 8'd96;
        HB = 1'b1;
        @(negedge clk);
        HB = 1'b0;
        chk("ab_valid_drop", hit_valid, 0);
        chk("ab_busy", scan_busy, 1);
        chk("ab_addr0", obj_addr, 0);
        collect(0);
        chk("ab_n", got.size(), 1);
        if (got.size() == 1) begin
            chk("ab_x", got[0].x, 9);
            chk("ab_row", got[0].row, 7);
        end

        // HB rise without pxl_cen must not start a scan
        @(negedge clk);
        pxl_cen = 1'b0;
        HB = 1'b1;
        repeat (3) @(negedge clk);
        chk("cen_gate", scan_busy, 0);
        HB = 1'b0;
        @(negedge clk);
        pxl_cen = 1'b1;
        @(negedge clk);
        chk("cen_gate2", scan_busy, 0);

        // Reset mid-scan
        start_line(8'd44);
        repeat (5) @(negedge clk);
        chk("mid_busy", scan_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", scan_busy, 0);
        chk("mid_rst_addr", obj_addr, 0);
        chk("mid_rst_x", hit_x, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
